// File: rtl/fp_addsub_sched.sv
// Round-robin scheduler sharing one FP add/sub unit among NREQ requesters.
// Each operation is registered and issued to the unit. The result is returned with the
// requester's tag, and a sticky exception-flag register is kept.
module fp_addsub_sched #(
   parameter int unsigned NREQ = 2,
   parameter int unsigned TAGW = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [32*NREQ-1:0]   req_a,
   input  logic [32*NREQ-1:0]   req_b,
   input  logic [NREQ-1:0]      req_sub,
   input  logic [TAGW*NREQ-1:0] req_tag,
   output logic [NREQ-1:0]      resp_valid,
   input  logic [NREQ-1:0]      resp_ready,
   output logic [31:0]          resp_y,
   output logic [4:0]           resp_flags,
   output logic [TAGW-1:0]      resp_tag,
   output logic                 fu_start,
   output logic                 fu_sub,
   output logic [31:0]          fu_a,
   output logic [31:0]          fu_b,
   input  logic [31:0]          fu_y,
   input  logic [4:0]           fu_flags,
   input  logic                 fu_valid,
   output logic [4:0]           fflags,
   input  logic                 fflags_clr,
   output logic                 busy
);

   localparam int unsigned LW = $clog2(NREQ);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   state_e            r_state, w_state_next;
   logic [LW-1:0]     r_last;
   logic [31:0]       r_a, r_b, r_y;
   logic              r_sub;
   logic [TAGW-1:0]   r_tag;
   logic [4:0]        r_flags, r_fflags;

   logic              w_found, w_accept, w_resp_hs;
   logic [LW-1:0]     w_gidx, w_cand;
   logic [31:0]       w_sel_a, w_sel_b;
   logic              w_sel_sub;
   logic [TAGW-1:0]   w_sel_tag;

   // Round-robin search starting just after the last winner, wrapping modulo NREQ.
   always_comb begin
      w_found = 1'b0;
      w_gidx  = '0;
      w_cand  = '0;
      for (int k = 1; k <= int'(NREQ); k++) begin
         w_cand = LW'((int'(r_last) + k) % int'(NREQ));
         if (!w_found && req_valid[w_cand]) begin
            w_found = 1'b1;
            w_gidx  = w_cand;
         end
      end
   end

   // Select the winning requester's operation fields.
   always_comb begin
      w_sel_a   = '0;
      w_sel_b   = '0;
      w_sel_sub = 1'b0;
      w_sel_tag = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (w_gidx == LW'(i)) begin
            w_sel_a   = req_a[32*i +: 32];
            w_sel_b   = req_b[32*i +: 32];
            w_sel_sub = req_sub[i];
            w_sel_tag = req_tag[TAGW*i +: TAGW];
         end
      end
   end

   // Gated by rst so that req_ready reads 0 while reset is held, even with requests pending.
   assign w_accept  = (r_state == StIdle) && w_found && !rst;
   assign w_resp_hs = (r_state == StResp) && resp_ready[r_last];

   // Next-state logic.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         StIdle:  if (w_accept) w_state_next = StIssue;
         StIssue: w_state_next = StWait;
         StWait:  if (fu_valid) w_state_next = StResp;
         StResp:  if (w_resp_hs) w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   // One-hot handshake outputs. The owner of the in-flight operation is r_last.
   always_comb begin
      req_ready  = '0;
      resp_valid = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         req_ready[i]  = w_accept && (w_gidx == LW'(i));
         resp_valid[i] = (r_state == StResp) && (r_last == LW'(i));
      end
   end

   // State, operand, result and sticky-flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= StIdle;
         r_last   <= LW'(NREQ - 1);
         r_a      <= '0;
         r_b      <= '0;
         r_sub    <= 1'b0;
         r_tag    <= '0;
         r_y      <= '0;
         r_flags  <= '0;
         r_fflags <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_last <= w_gidx;
            r_a    <= w_sel_a;
            r_b    <= w_sel_b;
            r_sub  <= w_sel_sub;
            r_tag  <= w_sel_tag;
         end
         if ((r_state == StWait) && fu_valid) begin
            r_y     <= fu_y;
            r_flags <= fu_flags;
         end
         // A clear in the same cycle as a handshake clears first, then ORs.
         if (w_resp_hs && fflags_clr) begin
            r_fflags <= r_flags;
         end else if (w_resp_hs) begin
            r_fflags <= r_fflags | r_flags;
         end else if (fflags_clr) begin
            r_fflags <= '0;
         end
      end
   end

   assign fu_start   = (r_state == StIssue);
   assign fu_sub     = r_sub;
   assign fu_a       = r_a;
   assign fu_b       = r_b;
   assign resp_y     = r_y;
   assign resp_flags = r_flags;
   assign resp_tag   = r_tag;
   assign fflags     = r_fflags;
   assign busy       = (r_state != StIdle);

endmodule

// File: tb/tb_fp_addsub_sched.sv
// Directed testbench for fp_addsub_sched with a one-cycle FP unit model.
module tb_fp_addsub_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid, req_ready, req_sub, resp_valid, resp_ready;
   logic [63:0] req_a, req_b;
   logic [9:0]  req_tag;
   logic [31:0] resp_y, fu_a, fu_b, fu_y;
   logic [4:0]  resp_flags, resp_tag, fu_flags, fflags;
   logic        fu_start, fu_sub, fu_valid, fflags_clr, busy;

   int          n_vec = 0;
   int          n_err = 0;
   logic [1:0]  exp_g;

   fp_addsub_sched #(.NREQ(2), .TAGW(5)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
      .req_sub(req_sub), .req_tag(req_tag),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_y(resp_y),
      .resp_flags(resp_flags), .resp_tag(resp_tag),
      .fu_start(fu_start), .fu_sub(fu_sub), .fu_a(fu_a), .fu_b(fu_b),
      .fu_y(fu_y), .fu_flags(fu_flags), .fu_valid(fu_valid),
      .fflags(fflags), .fflags_clr(fflags_clr), .busy(busy)
   );

   always #5 clk = ~clk;

   // FP unit stand-in: known vectors return hand-computed results, anything else a ^ b.
   function automatic logic [36:0] fu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
      if (!s && a == 32'h3F80_0000 && b == 32'h4000_0000) return {5'b00000, 32'h4040_0000};
      if (s && a == 32'h4040_0000 && b == 32'h3F80_0000)  return {5'b00000, 32'h4000_0000};
      if (!s && a == 32'h3F80_0000 && b == 32'h3380_0000) return {5'b00001, 32'h3F80_0000};
      if (!s && a == 32'h7F7F_FFFF && b == 32'h7F7F_FFFF) return {5'b00101, 32'h7F80_0000};
      return {5'b00000, a ^ b};
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         fu_valid <= 1'b0;
         fu_y     <= '0;
         fu_flags <= '0;
      end else begin
         fu_valid <= fu_start;
         if (fu_start) {fu_flags, fu_y} <= fu_model(fu_a, fu_b, fu_sub);
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; req_valid = 2'b11; req_a = '0; req_b = '0; req_sub = '0; req_tag = '0;
      resp_ready = '0; fflags_clr = 1'b0;
      #2;
      chk("rst_req_ready", req_ready, 2'b00);
      chk("rst_resp_valid", resp_valid, 2'b00);
      chk("rst_fu_start", fu_start, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_resp_y", resp_y, 32'h0);
      chk("rst_fflags", fflags, 5'h0);
      chk("rst_fu_a", fu_a, 32'h0);
      req_valid = 2'b00;
      @(negedge clk); rst = 1'b0;

      // Single add from requester 0.
      @(negedge clk);
      req_a[31:0] = 32'h3F80_0000; req_b[31:0] = 32'h4000_0000; req_tag[4:0] = 5'd3;
      req_valid = 2'b01; #1;
      chk("add_c0_ready", req_ready, 2'b01);
      @(negedge clk); req_valid = 2'b00; #1;
      chk("add_c1_start", fu_start, 1'b1);
      chk("add_c1_fu_a", fu_a, 32'h3F80_0000);
      chk("add_c1_fu_b", fu_b, 32'h4000_0000);
      chk("add_c1_busy", busy, 1'b1);
      @(negedge clk); #1;
      chk("add_c2_start", fu_start, 1'b0);
      chk("add_c2_resp_valid", resp_valid, 2'b00);
      @(negedge clk); #1;
      chk("add_c3_resp_valid", resp_valid, 2'b01);
      chk("add_y", resp_y, 32'h4040_0000);
      chk("add_flags", resp_flags, 5'h0);
      chk("add_tag", resp_tag, 5'd3);
      chk("add_fflags", fflags, 5'h0);
      resp_ready = 2'b11;
      @(negedge clk); #1;
      chk("add_done_busy", busy, 1'b0);

      // Subtract from requester 1.
      req_a[63:32] = 32'h4040_0000; req_b[63:32] = 32'h3F80_0000; req_sub = 2'b10;
      req_tag[9:5] = 5'd7; req_valid = 2'b10; #1;
      chk("sub_ready", req_ready, 2'b10);
      @(negedge clk); req_valid = 2'b00;
      @(negedge clk);
      @(negedge clk); #1;
      chk("sub_resp_valid", resp_valid, 2'b10);
      chk("sub_y", resp_y, 32'h4000_0000);
      chk("sub_tag", resp_tag, 5'd7);

      // Fairness: both requesters always pending, resp_ready held high.
      @(negedge clk);
      req_a = {32'h4444_4444, 32'h1111_1111}; req_b = {32'h1111_1111, 32'h2222_2222};
      req_sub = 2'b00; req_tag = {5'd2, 5'd1}; req_valid = 2'b11; #1;
      for (int i = 0; i < 4; i++) begin
         exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
         chk("fair_grant", req_ready, exp_g);
         @(negedge clk); #1;
         chk("fair_start", fu_start, 1'b1);
         chk("fair_ready_low", req_ready, 2'b00);
         @(negedge clk);
         @(negedge clk); #1;
         chk("fair_resp_valid", resp_valid, exp_g);
         chk("fair_y", resp_y, (i % 2 == 0) ? 32'h3333_3333 : 32'h5555_5555);
         chk("fair_tag", resp_tag, (i % 2 == 0) ? 5'd1 : 5'd2);
         @(negedge clk); #1;
      end

      // Backpressure: requester 0 keeps requesting while its response is held.
      req_a[31:0] = 32'h3F80_0000; req_b[31:0] = 32'h4000_0000; req_tag[4:0] = 5'd3;
      req_valid = 2'b01; resp_ready = 2'b00; #1;
      chk("bp_grant", req_ready, 2'b01);
      @(negedge clk);
      @(negedge clk);
      for (int j = 0; j < 5; j++) begin
         @(negedge clk); #1;
         chk("bp_resp_valid", resp_valid, 2'b01);
         chk("bp_y", resp_y, 32'h4040_0000);
         chk("bp_tag", resp_tag, 5'd3);
         chk("bp_req_ready", req_ready, 2'b00);
         chk("bp_fu_start", fu_start, 1'b0);
      end
      resp_ready = 2'b01;
      req_b[31:0] = 32'h3380_0000; req_tag[4:0] = 5'd9;
      @(negedge clk); #1;
      chk("bp_reaccept", req_ready, 2'b01);
      chk("bp_resp_gone", resp_valid, 2'b00);

      // Tie rounds to even, raises NX.
      @(negedge clk); req_valid = 2'b00;
      @(negedge clk);
      @(negedge clk); #1;
      chk("tie_y", resp_y, 32'h3F80_0000);
      chk("tie_flags", resp_flags, 5'b00001);
      chk("tie_tag", resp_tag, 5'd9);
      @(negedge clk); #1;
      chk("tie_fflags", fflags, 5'b00001);

      // Clear alone.
      fflags_clr = 1'b1;
      @(negedge clk); fflags_clr = 1'b0; #1;
      chk("clr_alone", fflags, 5'b00000);

      // Overflow sets OF|NX sticky.
      req_a[31:0] = 32'h7F7F_FFFF; req_b[31:0] = 32'h7F7F_FFFF; req_tag[4:0] = 5'd4;
      req_valid = 2'b01;
      @(negedge clk); req_valid = 2'b00;
      @(negedge clk);
      @(negedge clk); #1;
      chk("of_flags", resp_flags, 5'b00101);
      @(negedge clk); #1;
      chk("of_fflags", fflags, 5'b00101);

      // Clear coinciding with an NX response handshake.
      req_a[31:0] = 32'h3F80_0000; req_b[31:0] = 32'h3380_0000; req_valid = 2'b01;
      resp_ready = 2'b00;
      @(negedge clk); req_valid = 2'b00;
      @(negedge clk);
      @(negedge clk); #1;
      chk("clrhs_flags", resp_flags, 5'b00001);
      fflags_clr = 1'b1; resp_ready = 2'b01;
      @(negedge clk); fflags_clr = 1'b0; #1;
      chk("clrhs_fflags", fflags, 5'b00001);

      // Reset during WAIT.
      req_a[31:0] = 32'h3F80_0000; req_b[31:0] = 32'h4000_0000; req_tag[4:0] = 5'd3;
      req_valid = 2'b01;
      @(negedge clk); req_valid = 2'b00;
      @(negedge clk); #1;
      rst = 1'b1; #1;
      chk("mid_rst_req_ready", req_ready, 2'b00);
      chk("mid_rst_resp_valid", resp_valid, 2'b00);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_resp_y", resp_y, 32'h0);
      chk("mid_rst_resp_tag", resp_tag, 5'h0);
      chk("mid_rst_fu_a", fu_a, 32'h0);
      chk("mid_rst_fu_b", fu_b, 32'h0);
      chk("mid_rst_fflags", fflags, 5'h0);
      @(negedge clk); rst = 1'b0;
      @(negedge clk); #1;
      chk("post_rst_no_resp", resp_valid, 2'b00);
      chk("post_rst_idle", busy, 1'b0);
      req_a[31:0] = 32'h4040_0000; req_b[31:0] = 32'h3F80_0000; req_sub = 2'b01;
      req_tag[4:0] = 5'd12; req_valid = 2'b01; resp_ready = 2'b01; #1;
      chk("post_rst_grant", req_ready, 2'b01);
      @(negedge clk); req_valid = 2'b00; #1;
      chk("post_rst_start", fu_start, 1'b1);
      @(negedge clk);
      @(negedge clk); #1;
      chk("post_rst_resp_valid", resp_valid, 2'b01);
      chk("post_rst_y", resp_y, 32'h4000_0000);
      chk("post_rst_tag", resp_tag, 5'd12);
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
